// File: rtl/mod_exp_if.sv
// Operand/result bundle for the 8-bit modular exponentiation engine.
interface mod_exp_if;
  logic [7:0] base;
  logic [7:0] exp;
  logic [7:0] modulus;
  logic       start;
  logic [7:0] result;
  logic       done;
  logic       busy;
  logic       err;

  modport master (output base, exp, modulus, start, input result, done, busy, err);
  modport slave  (input base, exp, modulus, start, output result, done, busy, err);
endinterface

// File: rtl/mod_exp.sv
// base^exp mod modulus, right-to-left square-and-multiply, one exponent bit per clock,
// always 8 iterations so latency is constant.
module mod_exp (
  input  logic       clk,
  input  logic       rst_n,
  mod_exp_if.slave   io
);
  typedef enum logic {IDLE, ITER} state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] b_q, b_d;
  logic [7:0] e_q, e_d;
  logic [7:0] m_q, m_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [15:0] prod_acc, prod_b;
  logic [7:0]  acc_mul, b_sq, acc_nxt, mod_nz;

  assign prod_acc = 16'(acc_q) * 16'(b_q);
  assign prod_b   = 16'(b_q) * 16'(b_q);
  // Remainders are < m_q, so truncation to 8 bits is lossless.
  assign acc_mul  = 8'(prod_acc % {8'h00, m_q});
  assign b_sq     = 8'(prod_b % {8'h00, m_q});
  assign acc_nxt  = e_q[0] ? acc_mul : acc_q;
  // Keeps the load-time reduction defined on the modulus==0 path, which never uses it.
  assign mod_nz   = (io.modulus == 8'd0) ? 8'd1 : io.modulus;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    e_d      = e_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          err_d = 1'b0;
          m_d   = io.modulus;
          if (io.modulus == 8'd0) begin
            result_d = 8'd0;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            acc_d   = (io.modulus == 8'd1) ? 8'd0 : 8'd1;
            b_d     = io.base % mod_nz;
            e_d     = io.exp;
            cnt_d   = 3'd0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        acc_d = acc_nxt;
        b_d   = b_sq;
        e_d   = e_q >> 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          result_d = acc_nxt;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= 8'd0;
      b_q      <= 8'd0;
      e_q      <= 8'd0;
      m_q      <= 8'd0;
      cnt_q    <= 3'd0;
      result_q <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      e_q      <= e_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign io.result = result_q;
  assign io.done   = done_q;
  assign io.busy   = (state_q == ITER);
  assign io.err    = err_q;
endmodule
